exe_vector_lane_unit: RTL and testbench
=======================================

// Module: exe_vector_lane_unit
// PURPOSE
//  EXE-stage consumer of the ID/EXE pipeline register. Latches one issued vector op, runs it
//  lane-serially (one 8-bit lane per cycle) on 32-bit packed vectors, and returns a vector or
//  scalar result with a done pulse. While busy it asserts stall so ID/EXE and earlier stages hold.
// PARAMETERS
//  LANES   4  number of lanes per vector
//  LANE_W  8  bits per lane; vector width = LANES*LANE_W = 32
// PORTS
//  clk           in   1   single clock; all state updates on posedge
//  rst_n         in   1   asynchronous, active-low reset
//  start         in   1   issue valid: op fields below are valid this cycle
//  flush         in   1   synchronous abort of the in-flight op
//  opcode_in     in   4   operation, see BEHAVIOUR
//  sel_vec_in    in   2   operand A source: 00 VEC1, 01 VFS, 10 VEC2, 11 zero
//  sel_op_in     in   1   operand B: 0 = VEC2 lane, 1 = sca1 broadcast
//  sel_int_in    in   1   1 = inmediato broadcast as B (overrides sel_op_in)
//  VEC1_in       in   32  vector operand 1
//  VEC2_in       in   32  vector operand 2
//  VFS_in        in   32  vector forward/source operand
//  sca1_in       in   8   scalar operand
//  inmediato_in  in   8   immediate operand
//  shift_in      in   8   shift amount; only [2:0] used
//  dir_dest_in   in   3   destination register index
//  stall         out  1   high in BUSY and DONE
//  done          out  1   one-cycle pulse, results valid that cycle
//  result_vec    out  32  vector result
//  result_sca    out  8   scalar (reduction) result
//  dir_dest_out  out  3   destination index of the completed op
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE; stall=0, done=0, result_vec=0, result_sca=0,
//    dir_dest_out=0, lane counter=0.
//  - FSM IDLE -> BUSY on start&!flush: capture all *_in fields into operand regs, lane=0.
//    BUSY: compute lane [lane*8 +: 8] into result_vec, lane++; at lane==LANES-1 -> DONE.
//    DONE: done=1 for exactly one cycle, -> IDLE. start ignored outside IDLE (upstream held by stall).
//  - Latency: start accepted at edge N -> done high in the cycle after edge N+LANES (LANES+1 edges).
//  - Opcodes (per lane, a=A lane, b=B lane, all mod 2^8, carries never cross lanes):
//    0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 SLL a<<sh; 6 SRL a>>sh (logical);
//    7 MUL low 8 bits of a*b; 8 RSUM result_sca = sum of all A lanes mod 256, result_vec=0;
//    9-15 pass A unchanged. result_sca holds previous value for non-RSUM ops.
//  - result_vec/result_sca/dir_dest_out hold stable from DONE until the next op's first BUSY write.
//  - flush in BUSY or DONE: -> IDLE next edge, done stays 0, result regs keep partial contents;
//    flush in IDLE blocks a simultaneous start. flush has priority over start.
//  - rst_n asserted mid-op: immediate return to reset values; op lost.
// STRUCTURE
//  - Package vpu_pkg: opcode localparams (OP_ADD..OP_RSUM), sel_vec encodings, FSM state enum.
//  - Sub-module vec_lane_alu: combinational 8-bit lane ALU (a, b, sh, opcode -> y); instanced once.
//  - Top: operand regs, lane mux/counter, RSUM accumulator, FSM.
// TESTING
//  - Reset mid-BUSY -> all outputs 0 immediately, stall=0, no done.
//  - ADD, VEC1=0x01FF7F10, VEC2=0x01010101 -> done after 5 edges, result_vec=0x0200 8011 (0x02008011), no lane carry.
//  - sel_int=1, inmediato=0x03, sel_op=1, MUL, VEC1=0x02040810 -> result_vec=0x060C1830.
//  - RSUM, sel_vec=01, VFS=0x80808001 -> result_sca=0x81, result_vec=0.
//  - SRL shift_in=0xF9 (sh=1), VEC1=0x80FF0102 -> result_vec=0x407F0001; dir_dest_out=dir_dest_in.
//  - flush at 2nd BUSY cycle, start+flush same cycle in IDLE -> no done, FSM IDLE, stall=0.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared widths, opcode encodings, operand-select encodings and FSM states for the vector lane unit.
package vpu_pkg;

    localparam int unsigned LANES      = 4;
    localparam int unsigned LANE_W     = 8;
    localparam int unsigned VEC_W      = LANES * LANE_W;
    localparam int unsigned LANE_IDX_W = $clog2(LANES);
    localparam int unsigned OP_W       = 4;
    localparam int unsigned SH_W       = 3;
    localparam int unsigned DEST_W     = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd7;
    localparam logic [OP_W-1:0] OP_RSUM = 4'd8;

    localparam logic [1:0] SEL_VEC1 = 2'b00;
    localparam logic [1:0] SEL_VFS  = 2'b01;
    localparam logic [1:0] SEL_VEC2 = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [VEC_W-1:0] bcast(input logic [LANE_W-1:0] x);
        return {LANES{x}};
    endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational single-lane ALU; all arithmetic wraps within the lane width.
module vec_lane_alu
    import vpu_pkg::*;
(
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    input  logic [SH_W-1:0]   sh_i,
    input  logic [OP_W-1:0]   op_i,
    output logic [LANE_W-1:0] y_o
);

    logic [2*LANE_W-1:0] prod_c;

    always_comb begin
        prod_c = a_i * b_i;
        y_o    = a_i;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_SLL:  y_o = a_i << sh_i;
            OP_SRL:  y_o = a_i >> sh_i;
            OP_MUL:  y_o = prod_c[LANE_W-1:0];
            OP_RSUM: y_o = '0;
            default: y_o = a_i;
        endcase
    end

endmodule

// File: rtl/exe_vector_lane_unit.sv
// EXE-stage vector unit: latches one issued op and processes one lane per cycle,
// stalling upstream until the done pulse.
module exe_vector_lane_unit
    import vpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                flush,
    input  logic [OP_W-1:0]     opcode_in,
    input  logic [1:0]          sel_vec_in,
    input  logic                sel_op_in,
    input  logic                sel_int_in,
    input  logic [VEC_W-1:0]    VEC1_in,
    input  logic [VEC_W-1:0]    VEC2_in,
    input  logic [VEC_W-1:0]    VFS_in,
    input  logic [LANE_W-1:0]   sca1_in,
    input  logic [LANE_W-1:0]   inmediato_in,
    input  logic [7:0]          shift_in,
    input  logic [DEST_W-1:0]   dir_dest_in,
    output logic                stall,
    output logic                done,
    output logic [VEC_W-1:0]    result_vec,
    output logic [LANE_W-1:0]   result_sca,
    output logic [DEST_W-1:0]   dir_dest_out
);

    state_e                 state_q;
    logic [LANE_IDX_W-1:0]  lane_q;
    logic [VEC_W-1:0]       a_vec_q;
    logic [VEC_W-1:0]       b_vec_q;
    logic [OP_W-1:0]        op_q;
    logic [SH_W-1:0]        sh_q;
    logic [DEST_W-1:0]      dest_q;
    logic [LANE_W-1:0]      acc_q;
    logic                   stall_q;
    logic                   done_q;
    logic [VEC_W-1:0]       res_vec_q;
    logic [LANE_W-1:0]      res_sca_q;
    logic [DEST_W-1:0]      dest_out_q;

    logic [VEC_W-1:0]       a_sel_c;
    logic [VEC_W-1:0]       b_sel_c;
    logic [LANE_W-1:0]      a_lane_c;
    logic [LANE_W-1:0]      b_lane_c;
    logic [LANE_W-1:0]      alu_y_c;
    logic [LANE_W-1:0]      acc_sum_c;

    // Operand selection at issue; B broadcasts are resolved into a full vector once.
    always_comb begin
        a_sel_c = '0;
        case (sel_vec_in)
            SEL_VEC1: a_sel_c = VEC1_in;
            SEL_VFS:  a_sel_c = VFS_in;
            SEL_VEC2: a_sel_c = VEC2_in;
            default:  a_sel_c = '0;
        endcase
        if (sel_int_in) begin
            b_sel_c = bcast(inmediato_in);
        end else if (sel_op_in) begin
            b_sel_c = bcast(sca1_in);
        end else begin
            b_sel_c = VEC2_in;
        end
    end

    always_comb begin
        a_lane_c  = a_vec_q[lane_q*LANE_W +: LANE_W];
        b_lane_c  = b_vec_q[lane_q*LANE_W +: LANE_W];
        acc_sum_c = acc_q + a_lane_c;
    end

    vec_lane_alu u_alu (
        .a_i  (a_lane_c),
        .b_i  (b_lane_c),
        .sh_i (sh_q),
        .op_i (op_q),
        .y_o  (alu_y_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lane_q     <= '0;
            a_vec_q    <= '0;
            b_vec_q    <= '0;
            op_q       <= '0;
            sh_q       <= '0;
            dest_q     <= '0;
            acc_q      <= '0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
            res_vec_q  <= '0;
            res_sca_q  <= '0;
            dest_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !flush) begin
                        a_vec_q <= a_sel_c;
                        b_vec_q <= b_sel_c;
                        op_q    <= opcode_in;
                        sh_q    <= shift_in[SH_W-1:0];
                        dest_q  <= dir_dest_in;
                        lane_q  <= '0;
                        acc_q   <= '0;
                        stall_q <= 1'b1;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        stall_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        res_vec_q[lane_q*LANE_W +: LANE_W] <= alu_y_c;
                        acc_q  <= acc_sum_c;
                        lane_q <= lane_q + LANE_IDX_W'(1);
                        if (lane_q == LANE_IDX_W'(LANES - 1)) begin
                            done_q     <= 1'b1;
                            dest_out_q <= dest_q;
                            state_q    <= ST_DONE;
                            if (op_q == OP_RSUM) begin
                                res_sca_q <= acc_sum_c;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    stall_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    stall_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall        = stall_q;
    assign done         = done_q;
    assign result_vec   = res_vec_q;
    assign result_sca   = res_sca_q;
    assign dir_dest_out = dest_out_q;

endmodule

// File: tb/tb_exe_vector_lane_unit.sv
// Scoreboard bench for exe_vector_lane_unit: directed ops push expectations, a monitor checks on done.
module tb_exe_vector_lane_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [3:0]  opcode_in;
    logic [1:0]  sel_vec_in;
    logic        sel_op_in;
    logic        sel_int_in;
    logic [31:0] VEC1_in;
    logic [31:0] VEC2_in;
    logic [31:0] VFS_in;
    logic [7:0]  sca1_in;
    logic [7:0]  inmediato_in;
    logic [7:0]  shift_in;
    logic [2:0]  dir_dest_in;
    logic        stall;
    logic        done;
    logic [31:0] result_vec;
    logic [7:0]  result_sca;
    logic [2:0]  dir_dest_out;

    typedef struct {
        logic [31:0] vec;
        logic [7:0]  sca;
        logic [2:0]  dest;
        int          t_done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ndone  = 0;
    int   cyc    = 0;

    exe_vector_lane_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .flush        (flush),
        .opcode_in    (opcode_in),
        .sel_vec_in   (sel_vec_in),
        .sel_op_in    (sel_op_in),
        .sel_int_in   (sel_int_in),
        .VEC1_in      (VEC1_in),
        .VEC2_in      (VEC2_in),
        .VFS_in       (VFS_in),
        .sca1_in      (sca1_in),
        .inmediato_in (inmediato_in),
        .shift_in     (shift_in),
        .dir_dest_in  (dir_dest_in),
        .stall        (stall),
        .done         (done),
        .result_vec   (result_vec),
        .result_sca   (result_sca),
        .dir_dest_out (dir_dest_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_vec", result_vec, e.vec);
                check("result_sca", 32'(result_sca), 32'(e.sca));
                check("dir_dest_out", 32'(dir_dest_out), 32'(e.dest));
                check("done_latency", 32'(cyc), 32'(e.t_done));
                check("stall_in_done", 32'(stall), 32'd1);
            end
            ndone++;
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [1:0] sv, input logic so, input logic si,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] vf,
                          input logic [7:0] s1, input logic [7:0] im, input logic [7:0] sh,
                          input logic [2:0] dst, input logic [31:0] ev, input logic [7:0] es);
        int n0;
        exp_t e;
        @(negedge clk);
        opcode_in = op; sel_vec_in = sv; sel_op_in = so; sel_int_in = si;
        VEC1_in = v1; VEC2_in = v2; VFS_in = vf; sca1_in = s1; inmediato_in = im;
        shift_in = sh; dir_dest_in = dst; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n0 = ndone;
        e.vec = ev; e.sca = es; e.dest = dst; e.t_done = cyc + 4;
        sb.push_back(e);
        check("stall_after_issue", 32'(stall), 32'd1);
        for (int k = 0; k < 20 && ndone == n0; k++) @(negedge clk);
        if (ndone == n0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles (t=%0t)", $time);
        end
        @(negedge clk);
        check("hold_result_vec", result_vec, ev);
        check("hold_dir_dest", 32'(dir_dest_out), 32'(dst));
        check("idle_done_low", 32'(done), 32'd0);
        check("idle_stall_low", 32'(stall), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_result_vec"}, result_vec, 32'd0);
        check({tag, "_result_sca"}, 32'(result_sca), 32'd0);
        check({tag, "_dir_dest"}, 32'(dir_dest_out), 32'd0);
    endtask

    initial begin
        int n0;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        opcode_in = '0; sel_vec_in = '0; sel_op_in = 1'b0; sel_int_in = 1'b0;
        VEC1_in = '0; VEC2_in = '0; VFS_in = '0; sca1_in = '0; inmediato_in = '0;
        shift_in = '0; dir_dest_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // op, sel_vec, sel_op, sel_int, VEC1, VEC2, VFS, sca1, imm, shift, dest, exp_vec, exp_sca
        run_op(4'd0, 2'b00, 1'b0, 1'b0, 32'h01FF7F10, 32'h01010101, 32'h0, 8'h00, 8'h00, 8'h00, 3'd5, 32'h02008011, 8'h00);
        run_op(4'd7, 2'b00, 1'b1, 1'b1, 32'h02040810, 32'hFFFFFFFF, 32'h0, 8'h55, 8'h03, 8'h00, 3'd2, 32'h060C1830, 8'h00);
        run_op(4'd8, 2'b01, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 32'h80808001, 8'h00, 8'h00, 8'h00, 3'd7, 32'h00000000, 8'h81);
        run_op(4'd6, 2'b00, 1'b0, 1'b0, 32'h80FF0102, 32'h0, 32'h0, 8'h00, 8'h00, 8'hF9, 3'd3, 32'h407F0001, 8'h81);
        run_op(4'd1, 2'b10, 1'b1, 1'b0, 32'hAAAAAAAA, 32'h10050300, 32'h0, 8'h04, 8'h00, 8'h00, 3'd1, 32'h0C01FFFC, 8'h81);
        run_op(4'd5, 2'b00, 1'b0, 1'b0, 32'h81402001, 32'h0, 32'h0, 8'h00, 8'h00, 8'h03, 3'd4, 32'h08000008, 8'h81);
        run_op(4'd4, 2'b00, 1'b0, 1'b0, 32'hFF00AA55, 32'h0F0F0F0F, 32'h0, 8'h00, 8'h00, 8'h00, 3'd6, 32'hF00FA55A, 8'h81);
        run_op(4'd3, 2'b11, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 32'h0, 8'h00, 8'h00, 8'h00, 3'd0, 32'h12345678, 8'h81);
        run_op(4'd2, 2'b00, 1'b0, 1'b0, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h0, 8'h00, 8'h00, 8'h00, 3'd2, 32'h30303030, 8'h81);
        run_op(4'd12, 2'b00, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0, 8'h77, 8'h00, 8'h00, 3'd7, 32'hDEADBEEF, 8'h81);

        // Asynchronous reset in the middle of an op: outputs clear at once, no done follows.
        @(negedge clk);
        opcode_in = 4'd0; sel_vec_in = 2'b00; sel_op_in = 1'b0; sel_int_in = 1'b0;
        VEC1_in = 32'h01010101; VEC2_in = 32'h01010101; dir_dest_in = 3'd6; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Flush during the second busy cycle, then start+flush together in idle.
        n0 = ndone;
        @(negedge clk);
        VEC1_in = 32'h01010101; VEC2_in = 32'h01010101; dir_dest_in = 3'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_stall_low", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("start_flush_blocked", 32'(stall), 32'd0);
        repeat (8) @(negedge clk);
        check("flush_no_done", 32'(ndone - n0), 32'd0);
        check("flush_idle_stall", 32'(stall), 32'd0);

        // Recovery after flush; scalar result was cleared by the earlier reset.
        run_op(4'd0, 2'b00, 1'b0, 1'b0, 32'h01FF7F10, 32'h01010101, 32'h0, 8'h00, 8'h00, 8'h00, 3'd1, 32'h02008011, 8'h00);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
